// File: rtl/mma_loop_sequencer.sv
// Walks the (row_i, col_j, inner_k) index space of C[MxN] = A[MxK] * B[KxN]
// with inner_k innermost, handing one tuple per valid/ready transfer to the datapath.
module mma_loop_sequencer #(
  parameter int DIM_WIDTH   = 8,
  parameter int CYCLE_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DIM_WIDTH-1:0]   dim_m,
  input  logic [DIM_WIDTH-1:0]   dim_n,
  input  logic [DIM_WIDTH-1:0]   dim_k,
  input  logic                   abort,
  output logic                   idx_valid,
  input  logic                   idx_ready,
  output logic [DIM_WIDTH-1:0]   row_i,
  output logic [DIM_WIDTH-1:0]   col_j,
  output logic [DIM_WIDTH-1:0]   inner_k,
  output logic                   first_k,
  output logic                   last_k,
  output logic                   busy,
  output logic                   done,
  output logic                   err_dim,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic [1:0]             state_dbg
);

  // Handshake: a tuple moves on every edge where idx_valid and idx_ready are both
  // high; idx_valid never waits on idx_ready and the tuple is frozen until it moves.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [DIM_WIDTH-1:0]   DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = {{(CYCLE_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [DIM_WIDTH-1:0] m_q, n_q, k_q;
  logic                 dims_ok;
  logic                 xfer;
  logic                 k_wrap, j_wrap, i_wrap;
  logic                 last_tuple;

  assign dims_ok = (dim_m != '0) && (dim_n != '0) && (dim_k != '0);
  assign xfer    = (state_q == S_RUN) && idx_ready;

  // Compare against dim-1 so a dimension of all ones never needs a wider counter.
  assign k_wrap     = (inner_k == (k_q - DIM_ONE));
  assign j_wrap     = (col_j == (n_q - DIM_ONE));
  assign i_wrap     = (row_i == (m_q - DIM_ONE));
  assign last_tuple = k_wrap && j_wrap && i_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start && dims_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                   state_d = S_IDLE;
        else if (xfer && last_tuple) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      row_i       <= '0;
      col_j       <= '0;
      inner_k     <= '0;
      cycle_count <= '0;
      err_dim     <= 1'b0;
    end else begin
      err_dim <= (state_q == S_IDLE) && start && !dims_ok;
      case (state_q)
        S_IDLE: begin
          if (start && dims_ok) begin
            m_q         <= dim_m;
            n_q         <= dim_n;
            k_q         <= dim_k;
            row_i       <= '0;
            col_j       <= '0;
            inner_k     <= '0;
            cycle_count <= '0;
          end
        end
        S_RUN: begin
          cycle_count <= cycle_count + CYC_ONE;
          // Abort wins over a coincident transfer, so the indices stay put.
          if (!abort && idx_ready) begin
            if (k_wrap) begin
              inner_k <= '0;
              if (j_wrap) begin
                col_j <= '0;
                row_i <= i_wrap ? '0 : row_i + DIM_ONE;
              end else begin
                col_j <= col_j + DIM_ONE;
              end
            end else begin
              inner_k <= inner_k + DIM_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign idx_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign first_k   = (state_q == S_RUN) && (inner_k == '0);
  assign last_k    = (state_q == S_RUN) && k_wrap;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mma_loop_sequencer.sv
// Directed bench for mma_loop_sequencer: expected tuples are queued when a job is
// started and a negedge monitor compares every presented tuple against the queue.
module tb_mma_loop_sequencer;

  localparam int DW = 8;
  localparam int CW = 32;
  localparam int TW = 3 * DW + 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] dim_m = '0, dim_n = '0, dim_k = '0;
  logic          abort = 1'b0;
  logic          idx_valid;
  logic          idx_ready = 1'b0;
  logic [DW-1:0] row_i, col_j, inner_k;
  logic          first_k, last_k, busy, done, err_dim;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state_dbg;

  mma_loop_sequencer #(.DIM_WIDTH(DW), .CYCLE_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
    .abort(abort), .idx_valid(idx_valid), .idx_ready(idx_ready),
    .row_i(row_i), .col_j(col_j), .inner_k(inner_k),
    .first_k(first_k), .last_k(last_k),
    .busy(busy), .done(done), .err_dim(err_dim),
    .cycle_count(cycle_count), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [TW-1:0] exp_q[$];
  logic [TW-1:0] cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] tup(input int i, input int j, input int k, input int kd);
    return {DW'(i), DW'(j), DW'(k), (k == 0), (k == kd - 1)};
  endfunction

  task automatic push_expected(input int m, input int n, input int k, input int limit);
    int cnt = 0;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          if (cnt < limit) exp_q.push_back(tup(i, j, kk, k));
          cnt++;
        end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (idx_valid) begin
      cur = {row_i, col_j, inner_k, first_k, last_k};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tuple: got 0x%0h expected none at %0t", cur, $time);
      end else if (idx_ready) begin
        check("transfer_tuple", 32'(cur), 32'(exp_q.pop_front()));
      end else begin
        check("stall_hold", 32'(cur), 32'(exp_q[0]));
      end
    end
  end

  // driver helpers
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dims(input int m, input int n, input int k);
    dim_m = DW'(m);
    dim_n = DW'(n);
    dim_k = DW'(k);
  endtask

  task automatic run_full(input string name, input int m, input int n, input int k);
    int waited = 0;
    idx_ready = 1'b1;
    push_expected(m, n, k, 1 << 30);
    set_dims(m, n, k);
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (!done && waited < 2000) begin
      step(1);
      waited++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_cycles"}, cycle_count, 32'(m * n * k));
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    step(1);
    check({name, "_idle"}, 32'(state_dbg), 32'(ST_IDLE));
  endtask

  initial begin
    // reset state
    #1 reset = 1'b1;
    #2;
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_flags", 32'({idx_valid, busy, done, err_dim, first_k, last_k}), 32'd0);
    check("rst_indices", 32'({row_i, col_j, inner_k}), 32'd0);
    check("rst_cycles", cycle_count, 32'd0);
    step(2);
    reset = 1'b0;
    step(1);

    // 2x2x2, ready always high; start and dims wiggle during the job
    idx_ready = 1'b1;
    push_expected(2, 2, 2, 64);
    set_dims(2, 2, 2);
    start = 1'b1;
    step(1);
    check("a_busy", 32'(busy), 32'd1);
    set_dims(3, 3, 3);
    step(7);
    check("a_still_run", 32'(state_dbg), 32'(ST_RUN));
    step(1);
    check("a_done", 32'({done, busy, idx_valid}), 32'b100);
    check("a_cycles", cycle_count, 32'd8);
    check("a_queue_empty", 32'(exp_q.size()), 32'd0);
    start = 1'b0;
    step(1);
    check("a_idle_after_done", 32'({state_dbg, done}), 32'({ST_IDLE, 1'b0}));
    step(1);
    check("a_no_restart", 32'(busy), 32'd0);
    check("a_cycles_hold", cycle_count, 32'd8);

    // 1x1x3 with ready low every other cycle
    push_expected(1, 1, 3, 64);
    set_dims(1, 1, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    idx_ready = 1'b0;
    repeat (6) begin
      step(1);
      idx_ready = ~idx_ready;
    end
    check("b_done", 32'(done), 32'd1);
    check("b_cycles", cycle_count, 32'd6);
    check("b_queue_empty", 32'(exp_q.size()), 32'd0);
    idx_ready = 1'b1;
    step(1);

    // zero dimension rejected
    set_dims(2, 0, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("c_err_dim", 32'(err_dim), 32'd1);
    check("c_quiet", 32'({busy, idx_valid, done}), 32'd0);
    check("c_state", 32'(state_dbg), 32'(ST_IDLE));
    step(1);
    check("c_err_pulse", 32'(err_dim), 32'd0);
    check("c_cycles_hold", cycle_count, 32'd6);

    // 4x4x4 aborted on the 5th transfer, then a 1x1x1 job
    push_expected(4, 4, 4, 5);
    set_dims(4, 4, 4);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("d_abort_stop", 32'({idx_valid, busy, done}), 32'd0);
    check("d_abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("d_abort_cycles", cycle_count, 32'd5);
    check("d_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (3) begin
      step(1);
      check("d_no_done", 32'(done), 32'd0);
    end
    push_expected(1, 1, 1, 64);
    set_dims(1, 1, 1);
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check("d_single_run", 32'(busy), 32'd1);
    step(1);
    check("d_single_done", 32'(done), 32'd1);
    check("d_single_cycles", cycle_count, 32'd1);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("d_single_idle", 32'({state_dbg, done}), 32'({ST_IDLE, 1'b0}));

    // asynchronous reset mid-run
    push_expected(3, 3, 3, 2);
    set_dims(3, 3, 3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    #2 reset = 1'b1;
    #1;
    check("e_rst_flags", 32'({idx_valid, busy, done, err_dim, first_k, last_k}), 32'd0);
    check("e_rst_indices", 32'({row_i, col_j, inner_k}), 32'd0);
    check("e_rst_cycles", cycle_count, 32'd0);
    check("e_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(posedge clk);
    #1 reset = 1'b0;
    step(3);
    check("e_waits_start", 32'(busy), 32'd0);
    check("e_queue_empty", 32'(exp_q.size()), 32'd0);

    // boundary sizes: K=1 flags and the largest dimension
    run_full("f_k1", 2, 3, 1);
    run_full("g_kmax", 1, 1, 255);
    run_full("h_nmax", 1, 255, 1);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
